// File: rtl/char_msg_pkg.sv
// Shared constants and state encoding for the text-overlay message scheduler.
package char_msg_pkg;

  localparam int ROWS         = 16;
  localparam int COLS         = 16;
  localparam int CODE_W       = 7;
  localparam int BLINK_PERIOD = 16;

  localparam logic [CODE_W-1:0] SPACE_CODE = 7'h20;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_CLEAR = 2'd1;
  localparam state_t ST_LOAD  = 2'd2;
  localparam state_t ST_SHOW  = 2'd3;

endpackage

// File: rtl/char_msg_sched_char_buf_ram.sv
// 256x7 character buffer: one write port, one registered read port (BRAM/LUTRAM style).
module char_buf_ram
  import char_msg_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [7:0]        waddr,
  input  logic [CODE_W-1:0] wdata,
  input  logic [7:0]        raddr,
  output logic [CODE_W-1:0] rdata
);

  logic [CODE_W-1:0] mem [0:ROWS*COLS-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the read register is reset; the array itself keeps its contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/char_msg_sched.sv
// Round-robin message scheduler: clears the char buffer, loads a ROM message, shows it for N frames.
// Optional blinking display in SHOW is enabled by defining CHAR_MSG_BLINK_EN.
module char_msg_sched
  import char_msg_pkg::*;
#(
  parameter int                NUM_REQ     = 4,
  parameter int                MSG_LEN     = 16,
  parameter int                MSG_ROW     = 0,
  parameter int                HOLD_FRAMES = 120,
  parameter logic [CODE_W-1:0] SPACE_CODE  = char_msg_pkg::SPACE_CODE
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  output logic [NUM_REQ-1:0]          ack,
  output logic                        done,
  output logic                        busy,
  input  logic                        vsync_in,
  output logic [$clog2(NUM_REQ)+3:0]  msg_rom_addr,
  input  logic [CODE_W-1:0]           msg_rom_data,
  input  logic [7:0]                  char_yx,
  output logic [CODE_W-1:0]           char_code,
  output logic                        enable,
  output state_t                      dbg_state
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int FW = $clog2(HOLD_FRAMES + 1);
  localparam int LW = $clog2(MSG_LEN + 1);

  state_t            state;
  logic [7:0]        clr_cnt;
  logic [LW-1:0]     load_cnt;
  logic [FW-1:0]     frame_cnt;
  logic [GW-1:0]     rr;
  logic [GW-1:0]     gidx;
  logic [GW-1:0]     grant;
  logic [GW-1:0]     rr_next;
  logic              any_req;
  logic              vsync_d;
  logic              vs_rise;
  logic              last_frame;
  logic              we;
  logic [7:0]        waddr;
  logic [CODE_W-1:0] wdata;
`ifdef CHAR_MSG_BLINK_EN
  logic              blink;
`endif

  // Scan downward so the lowest offset from rr overwrites the others and wins.
  always_comb begin
    int idx;
    idx     = 0;
    grant   = '0;
    any_req = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(rr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        grant   = GW'(idx);
        any_req = 1'b1;
      end
    end
  end

  assign rr_next = (grant == GW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

  always_comb begin
    ack = '0;
    if (state == ST_IDLE && any_req) ack[grant] = 1'b1;
  end

  assign vs_rise    = vsync_in & ~vsync_d;
  assign last_frame = vs_rise && (frame_cnt == FW'(HOLD_FRAMES - 1));
  assign done       = (state == ST_SHOW) && last_frame;
  assign busy       = (state != ST_IDLE);
  assign dbg_state  = state;

`ifdef CHAR_MSG_BLINK_EN
  assign enable = (state == ST_SHOW) & blink;
`else
  assign enable = (state == ST_SHOW);
`endif

  // ROM data lags its address by one cycle, so LOAD step k writes column k-1.
  assign msg_rom_addr = (state == ST_LOAD) ? {gidx, 4'(load_cnt)} : '0;

  always_comb begin
    we    = 1'b0;
    waddr = clr_cnt;
    wdata = SPACE_CODE;
    if (state == ST_CLEAR) begin
      we = 1'b1;
    end else if (state == ST_LOAD && load_cnt != '0) begin
      we    = 1'b1;
      waddr = {4'(MSG_ROW), 4'(load_cnt - 1'b1)};
      wdata = msg_rom_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rr        <= '0;
      gidx      <= '0;
      clr_cnt   <= '0;
      load_cnt  <= '0;
      frame_cnt <= '0;
      vsync_d   <= 1'b0;
`ifdef CHAR_MSG_BLINK_EN
      blink     <= 1'b1;
`endif
    end else begin
      vsync_d <= vsync_in;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            gidx    <= grant;
            rr      <= rr_next;
            clr_cnt <= '0;
            state   <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == 8'hFF) begin
            load_cnt <= '0;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (load_cnt == LW'(MSG_LEN)) begin
            frame_cnt <= '0;
`ifdef CHAR_MSG_BLINK_EN
            blink     <= 1'b1;
`endif
            state     <= ST_SHOW;
          end else begin
            load_cnt <= load_cnt + 1'b1;
          end
        end
        ST_SHOW: begin
          if (vs_rise) begin
            frame_cnt <= frame_cnt + 1'b1;
`ifdef CHAR_MSG_BLINK_EN
            if ((int'(frame_cnt) + 1) % BLINK_PERIOD == 0) blink <= ~blink;
`endif
            if (last_frame) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  char_buf_ram u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (char_yx),
    .rdata (char_code)
  );

endmodule

// File: tb/tb_char_msg_sched.sv
// Self-checking bench for char_msg_sched: vector table, randomized messages, async-abort sequence.
module tb_char_msg_sched;
  import char_msg_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int MSG_LEN = 16;
  localparam int MSG_ROW = 2;
  localparam int HOLD    = 40;
  localparam int GW      = 2;
  localparam int AW      = GW + 4;
  localparam int PRE     = 256 + MSG_LEN + 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] ack;
  logic               done;
  logic               busy;
  logic               vsync_in;
  logic [AW-1:0]      msg_rom_addr;
  logic [6:0]         msg_rom_data;
  logic [7:0]         char_yx;
  logic [6:0]         char_code;
  logic               enable;
  state_t             dbg_state;

  always #5 clk = ~clk;

  char_msg_sched #(
    .NUM_REQ     (NUM_REQ),
    .MSG_LEN     (MSG_LEN),
    .MSG_ROW     (MSG_ROW),
    .HOLD_FRAMES (HOLD),
    .SPACE_CODE  (7'h20)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .ack          (ack),
    .done         (done),
    .busy         (busy),
    .vsync_in     (vsync_in),
    .msg_rom_addr (msg_rom_addr),
    .msg_rom_data (msg_rom_data),
    .char_yx      (char_yx),
    .char_code    (char_code),
    .enable       (enable),
    .dbg_state    (dbg_state)
  );

  logic [6:0] rom [0:(1<<AW)-1];
  always @(posedge clk) msg_rom_data <= rom[msg_rom_addr];

  int         n_tests = 0;
  int         n_fail  = 0;
  int         rr_m    = 0;
  logic [6:0] exp_q[$];

  typedef struct {
    logic [3:0] req_pat;
    bit         hold;
    logic [3:0] late;
    bit         early_vs;
    logic [3:0] exp_ack;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r);
    for (int i = 0; i < NUM_REQ; i++)
      if (r[(rr_m + i) % NUM_REQ]) return (rr_m + i) % NUM_REQ;
    return -1;
  endfunction

  function automatic logic [6:0] exp_char(input int g, input logic [7:0] yx);
    logic [GW-1:0] gs;
    gs = GW'(g);
    if (int'(yx[7:4]) == MSG_ROW && int'(yx[3:0]) < MSG_LEN) return rom[{gs, yx[3:0]}];
    return 7'h20;
  endfunction

  function automatic bit exp_en(input int edges);
`ifdef CHAR_MSG_BLINK_EN
    return ((edges / 16) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic idle_cycle();
    @(posedge clk); #1;
    req = '0;
    @(negedge clk);
    check("idle", {ack, busy, enable, done}, 7'b0);
  endtask

  task automatic run_msg(input logic [3:0] req_pat, input bit hold, input logic [3:0] late,
                         input bit early_vs, input logic [3:0] exp_ack, input int abort_at);
    int   g;
    int   edges;
    logic vs_prev;
    bit   rise;
    bit   done_exp;
    g = -1;
    for (int i = 0; i < NUM_REQ; i++) if (exp_ack[i]) g = i;
    @(posedge clk); #1;
    req      = req_pat;
    vsync_in = 1'b0;
    @(negedge clk);
    check("ack_grant", ack, exp_ack);
    check("busy_idle", {busy, enable, done}, 3'b000);
    rr_m = (g + 1) % NUM_REQ;
    for (int c = 1; c <= PRE; c++) begin
      @(posedge clk); #1;
      if (!hold) req = (c >= 260) ? late : 4'b0;
      if (early_vs && c == PRE) vsync_in = 1'b1;
      @(negedge clk);
      check("clear_load", {ack, busy, enable, done}, {4'b0, 1'b1, 1'b0, 1'b0});
    end
    edges   = 0;
    vs_prev = vsync_in;
    exp_q.delete();
    for (int c = 0; c < HOLD * 4 + 20; c++) begin
      @(posedge clk); #1;
      if (abort_at > 0 && edges == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        check("abort_out", {ack, busy, enable, done}, 7'b0);
        check("abort_state", dbg_state, ST_IDLE);
        @(posedge clk); #1;
        rst_n = 1'b1;
        req   = '0;
        rr_m  = 0;
        return;
      end
      vsync_in = ((c % 4) < 2);
      rise     = vsync_in && !vs_prev;
      vs_prev  = vsync_in;
      if (c < MSG_LEN)       char_yx = {4'(MSG_ROW), 4'(c)};
      else if (c == MSG_LEN) char_yx = 8'hF0;
      else                   char_yx = 8'($urandom_range(0, 255));
      done_exp = rise && (edges + 1 == HOLD);
      @(negedge clk);
      if (c > 0) check("char_code", char_code, exp_q.pop_front());
      exp_q.push_back(exp_char(g, char_yx));
      check("show_out", {ack, busy, enable, done}, {4'b0, 1'b1, exp_en(edges), done_exp});
      if (rise) edges++;
      if (done_exp) return;
    end
    check("show_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    vec_t       vecs[10];
    logic [3:0] r;
    int         g;

    for (int i = 0; i < (1 << AW); i++) rom[i] = 7'($urandom_range(0, 127));
    rst_n    = 1'b0;
    req      = '0;
    vsync_in = 1'b0;
    char_yx  = 8'h00;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ack", ack, 4'b0);
    check("rst_flags", {busy, done, enable}, 3'b0);
    check("rst_char_code", char_code, 7'h0);
    check("rst_rom_addr", msg_rom_addr, 6'h0);
    check("rst_state", dbg_state, ST_IDLE);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycle();

    vecs[0] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 4'b0001};
    vecs[1] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 4'b0010};
    vecs[2] = '{4'b1111, 1'b1, 4'b0000, 1'b1, 4'b0100};
    vecs[3] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 4'b1000};
    vecs[4] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 4'b0001};
    vecs[5] = '{4'b0010, 1'b0, 4'b0000, 1'b1, 4'b0010};
    vecs[6] = '{4'b0001, 1'b0, 4'b0100, 1'b0, 4'b0001};
    vecs[7] = '{4'b0100, 1'b0, 4'b0000, 1'b0, 4'b0100};
    vecs[8] = '{4'b1010, 1'b0, 4'b0000, 1'b1, 4'b1000};
    vecs[9] = '{4'b1010, 1'b0, 4'b0000, 1'b0, 4'b0010};
    for (int i = 0; i < 10; i++)
      run_msg(vecs[i].req_pat, vecs[i].hold, vecs[i].late, vecs[i].early_vs, vecs[i].exp_ack, 0);
    idle_cycle();

    repeat (4) begin
      r = 4'($urandom_range(1, 15));
      g = pick(r);
      run_msg(r, 1'b0, 4'b0, 1'($urandom_range(0, 1)), 4'(1 << g), 0);
      idle_cycle();
    end

    r = 4'b0110;
    g = pick(r);
    run_msg(r, 1'b0, 4'b0, 1'b0, 4'(1 << g), 5);
    idle_cycle();
    g = pick(4'b1001);
    run_msg(4'b1001, 1'b0, 4'b0, 1'b0, 4'(1 << g), 0);
    idle_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
